// File: rtl/disable_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : disable_sequencer
// Brief    : Turns per-channel sensor disable requests into a timed drive
//            pause. The drive is disabled for the first HALF_CYC cycles, then
//            re-enabled while pause stays high until PAUSE_CYC cycles have
//            elapsed. Tracks contributing channels and a saturating count of
//            pauses started.
// Revision : 1.0 - initial release
// ============================================================================
module disable_sequencer #(
  parameter int N_SNS     = 2,
  parameter int CNT_W     = 27,
  parameter int PAUSE_CYC = 75_000,
  parameter int HALF_CYC  = 32_500,
  parameter int RETRIG    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SNS-1:0] sns_disable,
  input  logic [N_SNS-1:0] sns_mask,
  output logic             enable,
  output logic             pause,
  output logic             done,
  output logic [N_SNS-1:0] cause,
  output logic [7:0]       evt_cnt
);

  // Refuse to elaborate with a pause shape the timer cannot represent.
  if ((N_SNS < 1) || (HALF_CYC < 1) || (HALF_CYC >= PAUSE_CYC) ||
      (longint'(PAUSE_CYC) > ((longint'(1) << CNT_W) - longint'(1)))) begin : g_bad_params
    $error("disable_sequencer: require N_SNS>=1 and 1 <= HALF_CYC < PAUSE_CYC <= 2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] c_HALF_LAST  = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] c_PAUSE_LAST = CNT_W'(PAUSE_CYC - 1);
  localparam logic             c_RETRIG     = (RETRIG != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HALT   = 2'd1,
    S_RESUME = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_timer;
  logic [CNT_W-1:0]   w_timer_nxt;
  logic               r_enable;
  logic               r_pause;
  logic               r_done;
  logic               w_done_nxt;
  logic [N_SNS-1:0]   r_cause;
  logic [N_SNS-1:0]   w_cause_nxt;
  logic [7:0]         r_evt_cnt;
  logic [7:0]         w_evt_nxt;
  logic               w_start;
  logic [N_SNS-1:0]   w_act;
  logic               w_trig;
  logic               w_last;

  // Unmasked requests are level triggers; a held request re-triggers each cycle.
  assign w_act  = sns_disable & ~sns_mask;
  assign w_trig = |w_act;
  assign w_last = (r_timer == c_PAUSE_LAST);

  // Next-state, timer, cause and completion decode.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_done_nxt  = 1'b0;
    w_cause_nxt = r_cause;
    w_start     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_state_nxt = S_HALT;
          w_timer_nxt = '0;
          w_cause_nxt = w_act;
          w_start     = 1'b1;
        end
      end
      S_HALT, S_RESUME: begin
        if (w_last) begin
          // Completion; a trigger on the final cycle chains straight into a new pause.
          w_done_nxt  = 1'b1;
          w_timer_nxt = '0;
          if (w_trig) begin
            w_state_nxt = S_HALT;
            w_cause_nxt = w_act;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_trig && c_RETRIG) begin
          w_state_nxt = S_HALT;
          w_timer_nxt = '0;
          w_cause_nxt = r_cause | w_act;
          w_start     = 1'b1;
        end else begin
          w_timer_nxt = r_timer + CNT_W'(1);
          if (w_trig) begin
            w_cause_nxt = r_cause | w_act;
          end
          if ((r_state == S_HALT) && (r_timer == c_HALF_LAST)) begin
            w_state_nxt = S_RESUME;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Saturating pause-start counter.
  always_comb begin
    w_evt_nxt = r_evt_cnt;
    if (w_start && (r_evt_cnt != 8'hFF)) begin
      w_evt_nxt = r_evt_cnt + 8'd1;
    end
  end

  // State and registered outputs; outputs are derived from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_enable  <= 1'b1;
      r_pause   <= 1'b0;
      r_done    <= 1'b0;
      r_cause   <= '0;
      r_evt_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_enable  <= (w_state_nxt != S_HALT);
      r_pause   <= (w_state_nxt != S_IDLE);
      r_done    <= w_done_nxt;
      r_cause   <= w_cause_nxt;
      r_evt_cnt <= w_evt_nxt;
    end
  end

  assign enable  = r_enable;
  assign pause   = r_pause;
  assign done    = r_done;
  assign cause   = r_cause;
  assign evt_cnt = r_evt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_disable_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_disable_sequencer
// Brief    : Self-checking bench; two instances (RETRIG=0 / RETRIG=1) share
//            stimulus and are compared every cycle against a pause-age model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disable_sequencer;

  localparam int P = 10;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dis;
  logic [1:0] msk;

  logic       en [2];
  logic       pa [2];
  logic       dn [2];
  logic [1:0] ca [2];
  logic [7:0] ec [2];

  // Model: age = cycles into the current pause, -1 when idle.
  int         m_age   [2];
  logic [1:0] m_cause [2];
  int         m_cnt   [2];
  logic       m_done  [2];

  int checks   = 0;
  int failures = 0;
  int pcnt [2];
  int dcnt [2];
  int lcnt [2];

  always #5 clk = ~clk;

  disable_sequencer #(.N_SNS(2), .CNT_W(8), .PAUSE_CYC(P), .HALF_CYC(H), .RETRIG(0)) u_dut0 (
    .clk(clk), .rst(rst), .sns_disable(dis), .sns_mask(msk),
    .enable(en[0]), .pause(pa[0]), .done(dn[0]), .cause(ca[0]), .evt_cnt(ec[0])
  );

  disable_sequencer #(.N_SNS(2), .CNT_W(8), .PAUSE_CYC(P), .HALF_CYC(H), .RETRIG(1)) u_dut1 (
    .clk(clk), .rst(rst), .sns_disable(dis), .sns_mask(msk),
    .enable(en[1]), .pause(pa[1]), .done(dn[1]), .cause(ca[1]), .evt_cnt(ec[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_age[i]   = -1;
      m_cause[i] = 2'b00;
      m_cnt[i]   = 0;
      m_done[i]  = 1'b0;
    end
  endtask

  task automatic model_start(input int i, input logic [1:0] c);
    m_age[i]   = 0;
    m_cause[i] = c;
    if (m_cnt[i] < 255) m_cnt[i]++;
  endtask

  // One clock edge of the pause rules, using the inputs present at the edge.
  task automatic model_edge();
    logic [1:0] act;
    act = dis & ~msk;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (m_age[i] < 0) begin
        if (act != 2'b00) model_start(i, act);
      end else if (m_age[i] == P - 1) begin
        m_done[i] = 1'b1;
        if (act != 2'b00) model_start(i, act);
        else m_age[i] = -1;
      end else if ((act != 2'b00) && (i == 1)) begin
        model_start(i, m_cause[i] | act);
      end else begin
        m_age[i]++;
        m_cause[i] = m_cause[i] | act;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s/d%0d/enable", tag, i), 32'(en[i]), 32'(!((m_age[i] >= 0) && (m_age[i] < H))));
      check($sformatf("%s/d%0d/pause", tag, i), 32'(pa[i]), 32'(m_age[i] >= 0));
      check($sformatf("%s/d%0d/done", tag, i), 32'(dn[i]), 32'(m_done[i]));
      check($sformatf("%s/d%0d/cause", tag, i), 32'(ca[i]), 32'(m_cause[i]));
      check($sformatf("%s/d%0d/evt_cnt", tag, i), 32'(ec[i]), 32'(m_cnt[i]));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare_all(tag);
    for (int i = 0; i < 2; i++) begin
      pcnt[i] += int'(pa[i] === 1'b1);
      dcnt[i] += int'(dn[i] === 1'b1);
      lcnt[i] += int'(en[i] === 1'b0);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      pcnt[i] = 0;
      dcnt[i] = 0;
      lcnt[i] = 0;
    end
  endtask

  // Hold reset across one edge, then release just after an edge so the next edge is the first live one.
  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    compare_all("rst");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dis = 2'b00;
    msk = 2'b00;
    model_reset();
    clear_counts();
    #1;
    compare_all("por");

    // Single pulse on channel 0, driven on the first edge after reset release.
    apply_reset();
    clear_counts();
    dis = 2'b01;
    step("A");
    dis = 2'b00;
    repeat (13) step("A");
    for (int i = 0; i < 2; i++) begin
      check($sformatf("A/d%0d/pause_len", i), pcnt[i], 10);
      check($sformatf("A/d%0d/disable_len", i), lcnt[i], 4);
      check($sformatf("A/d%0d/done_cnt", i), dcnt[i], 1);
      check($sformatf("A/d%0d/cause", i), 32'(ca[i]), 32'h1);
      check($sformatf("A/d%0d/evt", i), 32'(ec[i]), 32'h1);
    end

    // Channel 1 pulsed at timer=6.
    apply_reset();
    clear_counts();
    dis = 2'b01;
    step("B");
    dis = 2'b00;
    repeat (6) step("B");
    dis = 2'b10;
    step("B");
    dis = 2'b00;
    repeat (20) step("B");
    check("B/d0/pause_len", pcnt[0], 10);
    check("B/d0/done_cnt", dcnt[0], 1);
    check("B/d0/cause", 32'(ca[0]), 32'h3);
    check("B/d0/evt", 32'(ec[0]), 32'h1);
    check("B/d1/pause_len", pcnt[1], 17);
    check("B/d1/disable_len", lcnt[1], 8);
    check("B/d1/done_cnt", dcnt[1], 1);
    check("B/d1/cause", 32'(ca[1]), 32'h3);
    check("B/d1/evt", 32'(ec[1]), 32'h2);

    // Masked channel held.
    apply_reset();
    clear_counts();
    msk = 2'b01;
    dis = 2'b01;
    repeat (50) step("D");
    for (int i = 0; i < 2; i++) begin
      check($sformatf("D/d%0d/pause_len", i), pcnt[i], 0);
      check($sformatf("D/d%0d/disable_len", i), lcnt[i], 0);
      check($sformatf("D/d%0d/evt", i), 32'(ec[i]), 32'h0);
    end
    msk = 2'b00;
    dis = 2'b00;

    // Channel 0 held: back-to-back pauses; the retriggering instance saturates evt_cnt.
    apply_reset();
    clear_counts();
    dis = 2'b01;
    repeat (300) step("E");
    check("E/d0/pause_len", pcnt[0], 300);
    check("E/d0/done_cnt", dcnt[0], 29);
    check("E/d0/evt", 32'(ec[0]), 32'd30);
    check("E/d1/done_cnt", dcnt[1], 0);
    check("E/d1/evt_sat", 32'(ec[1]), 32'd255);
    dis = 2'b00;
    repeat (12) step("E_drain");

    // Asynchronous reset at timer=2.
    apply_reset();
    clear_counts();
    dis = 2'b01;
    step("F");
    dis = 2'b00;
    repeat (2) step("F");
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all("F_async");
    @(posedge clk);
    #1;
    compare_all("F_hold");
    rst = 1'b0;
    clear_counts();
    repeat (15) step("F_after");
    for (int i = 0; i < 2; i++) begin
      check($sformatf("F/d%0d/pause_len", i), pcnt[i], 0);
      check($sformatf("F/d%0d/done_cnt", i), dcnt[i], 0);
    end

    // Random requests, masks and occasional resets.
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      dis = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      msk = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if ($urandom_range(0, 99) == 0) apply_reset();
      step("R");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disable_sequencer.md
DISABLE_SEQUENCER -- requirements
Module: disable_sequencer

Interface
REQ-001 The block SHALL have parameter N_SNS, default 2, meaning the number of sensor disable request channels (at least 1).
REQ-002 The block SHALL have parameter CNT_W, default 27, meaning the pause timer width in bits.
REQ-003 The block SHALL have parameter PAUSE_CYC, default 75_000, meaning the total pause length in clk cycles.
REQ-004 The block SHALL have parameter HALF_CYC, default 32_500, meaning the length in clk cycles of the drive-disabled portion at the start of a pause.
REQ-005 The block SHALL have parameter RETRIG, default 0, meaning 1 = a request during a pause restarts it and 0 = a request during a pause is ignored.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset, with ports: clk  input  1  system clock, rising edge; rst  input  1  reset.
REQ-007 The block SHALL have port: sns_disable  input  N_SNS  per-channel disable request, level-sampled each cycle.
REQ-008 The block SHALL have port: sns_mask  input  N_SNS  1 = ignore that channel.
REQ-009 The block SHALL have port: enable  output  1  drive enable, low while drive is disabled.
REQ-010 The block SHALL have port: pause  output  1  high for the whole pause.
REQ-011 The block SHALL have port: done  output  1  one-cycle pulse when a pause completes.
REQ-012 The block SHALL have port: cause  output  N_SNS  channels that contributed to the current or last pause.
REQ-013 The block SHALL have port: evt_cnt  output  8  count of pauses started, saturating.

Function
REQ-014 The block SHALL treat elaboration as invalid unless 1 <= HALF_CYC < PAUSE_CYC <= 2^CNT_W-1.
REQ-015 The block SHALL compute trig = |(sns_disable & ~sns_mask), with no synchronisation and no edge detection: a held request counts as a trigger on every cycle.
REQ-016 The block SHALL implement states IDLE, HALT (pause=1, enable=0) and RESUME (pause=1, enable=1), and SHALL register all outputs.
REQ-017 The block SHALL move from IDLE to HALT on the next clk edge when trig=1 in IDLE, with timer=0 in the first HALT cycle, giving one cycle of latency from request to enable low.
REQ-018 The block SHALL increment the timer by 1 in every HALT and RESUME cycle.
REQ-019 The block SHALL move from HALT to RESUME when timer == HALF_CYC-1, so enable is low for exactly HALF_CYC cycles.
REQ-020 The block SHALL move from RESUME to IDLE, clear the timer to 0 and assert done for that edge's following cycle when timer == PAUSE_CYC-1, so pause is high for exactly PAUSE_CYC cycles.
REQ-021 The block SHALL, when RETRIG=1 and trig=1 in HALT or RESUME, move to HALT with timer=0, set cause |= the active channels and increment evt_cnt.
REQ-022 The block SHALL, when RETRIG=0 and trig=1 in HALT or RESUME, leave state and timer unaffected and set cause |= the active channels, with no evt_cnt change.
REQ-023 The block SHALL handle trig=1 in the final pause cycle (timer == PAUSE_CYC-1) for either RETRIG value by pulsing done, going directly to HALT with timer=0 rather than to IDLE, loading cause with the active channels and incrementing evt_cnt.
REQ-024 The block SHALL, on a new pause started from IDLE, load cause with exactly the active channels (previous contents discarded).
REQ-025 The block SHALL hold cause unchanged in IDLE.
REQ-026 The block SHALL increment evt_cnt by 1 per pause start (REQ-017, REQ-021, REQ-023), saturating at 255 with no wrap.
REQ-027 The block SHALL keep done low except in the single cycle after a completion edge, and SHALL NOT produce a done pulse for a pause truncated by a retrigger.
REQ-028 The block SHALL never let the timer exceed PAUSE_CYC-1 and SHALL never let it wrap.

Reset
REQ-029 The block SHALL, while rst=1 and independent of clk, force state=IDLE, timer=0, enable=1, pause=0, done=0, cause=0, evt_cnt=0.
REQ-030 The block SHALL, on rst asserted mid-pause, abort the pause with no done pulse and, after release, require a fresh trig to start a pause.
REQ-031 The block SHALL treat a trig present on the first edge after rst deasserts as a normal IDLE trigger.

Verification
REQ-032 The bench SHALL run all scenarios with N_SNS=2, PAUSE_CYC=10, HALF_CYC=4.
REQ-033 The bench SHALL cover: 1-cycle pulse on sns_disable[0] at edge k -> enable low for edges k+1..k+4, pause high for k+1..k+10, done high in cycle k+11, cause=01, evt_cnt=1.
REQ-034 The bench SHALL cover: RETRIG=0, sns_disable[1] pulsed at timer=6 -> pause still ends at the original cycle, cause=11, evt_cnt=1.
REQ-035 The bench SHALL cover: RETRIG=1, sns_disable[1] pulsed at timer=6 -> enable low again for 4 cycles, total pause 7+10 cycles, exactly one done pulse, evt_cnt=2.
REQ-036 The bench SHALL cover: sns_mask=01 with sns_disable=01 held for 50 cycles -> no pause, enable=1 throughout, evt_cnt=0.
REQ-037 The bench SHALL cover: sns_disable[0] held high continuously -> back-to-back pauses of 10 cycles with done pulsing every 10 cycles, no IDLE gap, and evt_cnt incrementing per pause.
REQ-038 The bench SHALL cover: rst asserted asynchronously at timer=2 -> outputs reset immediately with no clk edge, and no done pulse.
